// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Bit counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder; the adding counterpart of the full-subtractor cell.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder, S = X + Y + Cin, LSB first through one fa_cell.
// Optional signed-overflow flag enabled by `define OVERFLOW_DETECT_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] x_sr, y_sr, sum_sr;
    logic             fa_s, fa_co;
    logic             accept, last_bit;

    assign accept   = in_valid & in_ready;
    assign last_bit = (state == S_SHIFT) && (cnt == CW'(WIDTH - 1));
    assign sum      = sum_sr;

    fa_cell u_fa (
        .a  (x_sr[0]),
        .b  (y_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)              state_nxt = S_SHIFT;
            S_SHIFT: if (last_bit)            state_nxt = S_DONE;
            S_DONE:  if (out_ready)           state_nxt = S_IDLE;
            default:                          state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Sum bits enter at the MSB, so after WIDTH shifts bit 0 has reached position 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            carry  <= 1'b0;
            x_sr   <= '0;
            y_sr   <= '0;
            sum_sr <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            x_sr  <= x;
            y_sr  <= y;
            carry <= cin;
            cnt   <= '0;
        end else if (state == S_SHIFT) begin
            sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
            x_sr   <= x_sr >> 1;
            y_sr   <= y_sr >> 1;
            carry  <= fa_co;
            cnt    <= cnt + CW'(1);
            if (last_bit) cout <= fa_co;
        end
    end

`ifdef OVERFLOW_DETECT_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst)           ovf_q <= 1'b0;
        else if (last_bit) ovf_q <= carry ^ fa_co;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 main instance, WIDTH=2 sweep instance).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [7:0] x, y, sum;
    logic       in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2, ovf2;
    logic [1:0] x2, y2, sum2;

    int checks   = 0;
    int failures = 0;

`ifdef OVERFLOW_DETECT_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .x(x2), .y(y2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One operation on the 8-bit instance; hold = cycles of backpressure in DONE.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] es, input logic ec, input logic eo,
                         input int hold, input string tag);
        int n;
        x = a; y = b; cin = c; out_ready = 1'b0; in_valid = 1'b1;
        chk({tag, ".rdy"}, in_ready, 1);
        cyc();
        in_valid = 1'b0; x = 8'hEE; y = 8'hEE; cin = 1'b1;
        n = 1;
        while (!out_valid && n < 40) begin
            cyc();
            n++;
        end
        chk({tag, ".lat"}, n, 9);
        chk({tag, ".sum"}, sum, es);
        chk({tag, ".cout"}, cout, ec);
        chk({tag, ".ovf"}, ovf, eo);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; x = 8'h5A; y = 8'h11;
            cyc();
            chk({tag, ".bp_vld"}, out_valid, 1);
            chk({tag, ".bp_rdy"}, in_ready, 0);
            chk({tag, ".bp_sum"}, sum, es);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk({tag, ".ret_vld"}, out_valid, 0);
        cyc();
        chk({tag, ".idle"}, in_ready, 1);
    endtask

    logic [7:0] bx [3] = '{8'h12, 8'h80, 8'hAA};
    logic [7:0] by [3] = '{8'h34, 8'h80, 8'h55};
    logic       bc [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] bs [3] = '{8'h46, 8'h01, 8'h00};
    logic       bco[3] = '{1'b0, 1'b1, 1'b1};

    initial begin
        int j, k, last, n, d, seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; cin = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; x2 = '0; y2 = '0; cin2 = 1'b0;
        repeat (2) cyc();
        chk("rst.rdy", in_ready, 1);
        chk("rst.vld", out_valid, 0);
        chk("rst.sum", sum, 0);
        chk("rst.cout", cout, 0);
        chk("rst.ovf", ovf, 0);
        rst = 1'b0;

        do_op(8'h03, 8'h05, 1'b1, 8'h09, 1'b0, 1'b0, 0, "inv");
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, "wrap");
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF_EXP, 0, "ovf");
        do_op(8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 1'b0, 5, "bp");

        // Abort mid-operation; in_valid alongside rst must not be accepted.
        x = 8'h44; y = 8'h11; cin = 1'b0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        rst = 1'b1; in_valid = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        chk("mrst.rdy", in_ready, 1);
        chk("mrst.vld", out_valid, 0);
        chk("mrst.sum", sum, 0);
        chk("mrst.cout", cout, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (out_valid || !in_ready) seen = 1;
        end
        chk("mrst.quiet", seen, 0);
        do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0, "post_rst");

        // Back-to-back with out_ready tied high.
        j = 0; k = 0; last = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 80 && k < 3; t++) begin
            if (in_ready) begin
                in_valid = (j < 3);
                if (j < 3) begin
                    x = bx[j]; y = by[j]; cin = bc[j];
                    if (j > 0) chk("b2b.gap", t - last, 10);
                    last = t;
                    j++;
                end
            end
            if (out_valid) begin
                chk("b2b.sum", sum, bs[k]);
                chk("b2b.cout", cout, bco[k]);
                k++;
            end
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b.count", k, 3);

        // WIDTH=2: rebuild minuend A from (D, B, Bin) of every full-subtractor vector.
        out_ready2 = 1'b1;
        for (int v = 0; v < 8; v++) begin
            d = (((v >> 2) & 1) - ((v >> 1) & 1) - (v & 1)) & 3;
            x2 = 2'(d); y2 = 2'((v >> 1) & 1); cin2 = 1'(v & 1); in_valid2 = 1'b1;
            cyc();
            in_valid2 = 1'b0;
            n = 0;
            while (!out_valid2 && n < 20) begin
                cyc();
                n++;
            end
            chk("w2.lat", n, 2);
            chk("w2.sum", sum2, (v >> 2) & 1);
            chk("w2.cout", cout2, ((d + ((v >> 1) & 1) + (v & 1)) >> 2) & 1);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
